pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_reg_pkg.sv | 12 +
 rtl/pipe_skid_reg_if.sv | 25 ++
 rtl/pipe_skid_reg_data_reg_sync_en.sv | 21 ++
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for Kabeta pipeline register slices: state encoding and Count width.
package kabeta_pipe_pkg;

  localparam int unsigned WID_COUNT = 2;

  typedef enum logic [WID_COUNT-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage : kabeta_pipe_pkg

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bundle between two pipeline stages plus the slice occupancy count.
interface pipe_skid_reg_if #(
  parameter int unsigned WID_DATA = 32
);
  import kabeta_pipe_pkg::*;

  logic                 InValid;
  logic                 InReady;
  logic [WID_DATA-1:0]  DataIn;
  logic                 OutValid;
  logic                 OutReady;
  logic [WID_DATA-1:0]  DataOut;
  logic [WID_COUNT-1:0] Count;

  modport master (
    output InValid, DataIn, OutReady,
    input  InReady, OutValid, DataOut, Count
  );

  modport slave (
    input  InValid, DataIn, OutReady,
    output InReady, OutValid, DataOut, Count
  );

endinterface : pipe_skid_reg_if

// File: rtl/pipe_skid_reg_data_reg_sync_en.sv
// Data register with synchronous active-high reset to a fixed value and load enable.
module data_reg_sync_en #(
  parameter int unsigned       WID       = 32,
  parameter logic [WID-1:0]    RST_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [WID-1:0] data_d,
  output logic [WID-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VALUE;
    end else if (en) begin
      data_q <= data_d;
    end
  end

endmodule : data_reg_sync_en

// File: rtl/pipe_skid_reg.sv
// Valid/ready register slice with a one-entry skid buffer and synchronous flush.
module pipe_skid_reg
  import kabeta_pipe_pkg::*;
#(
  parameter int unsigned         WID_DATA          = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE         = '0,
  parameter bit                  FLUSH_CLEARS_DATA = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  pipe_skid_reg_if.slave        bus
);

  state_e              state_q, state_d;
  logic                main_en, skid_en;
  logic [WID_DATA-1:0] main_d, skid_d;
  logic [WID_DATA-1:0] main_q, skid_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = bus.DataIn;
    skid_en = 1'b0;
    skid_d  = bus.DataIn;
    if (Flush) begin
      // Flush drops any same-cycle input; an output handshake already happened downstream.
      state_d = ST_EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_en = 1'b1;
        main_d  = RST_VALUE;
        skid_en = 1'b1;
        skid_d  = RST_VALUE;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (bus.InValid) begin
            state_d = ST_FULL;
            main_en = 1'b1;
          end
        end
        ST_FULL: begin
          if (bus.InValid && bus.OutReady) begin
            main_en = 1'b1;
          end else if (bus.InValid) begin
            state_d = ST_SKID;
            skid_en = 1'b1;
          end else if (bus.OutReady) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // InReady is low here, so InValid is deliberately ignored.
          if (bus.OutReady) begin
            state_d = ST_FULL;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  data_reg_sync_en #(
    .WID       (WID_DATA),
    .RST_VALUE (RST_VALUE)
  ) u_main (
    .clk    (Clock),
    .rst    (Reset),
    .en     (main_en),
    .data_d (main_d),
    .data_q (main_q)
  );

  data_reg_sync_en #(
    .WID       (WID_DATA),
    .RST_VALUE (RST_VALUE)
  ) u_skid (
    .clk    (Clock),
    .rst    (Reset),
    .en     (skid_en),
    .data_d (skid_d),
    .data_q (skid_q)
  );

  assign bus.OutValid = (state_q != ST_EMPTY);
  assign bus.InReady  = (state_q != ST_SKID);
  assign bus.DataOut  = main_q;
  assign bus.Count    = state_q;

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboarded checks of pipe_skid_reg with both flush-data variants side by side.
module tb_pipe_skid_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] data_in;
  logic       out_ready;

  int unsigned n_checks;
  int unsigned n_errors;

  pipe_skid_reg_if #(.WID_DATA(8)) bus0 ();
  pipe_skid_reg_if #(.WID_DATA(8)) bus1 ();

  assign bus0.InValid  = in_valid;
  assign bus0.DataIn   = data_in;
  assign bus0.OutReady = out_ready;
  assign bus1.InValid  = in_valid;
  assign bus1.DataIn   = data_in;
  assign bus1.OutReady = out_ready;

  pipe_skid_reg #(
    .WID_DATA          (8),
    .RST_VALUE         (8'hA5),
    .FLUSH_CLEARS_DATA (1'b0)
  ) dut_keep (
    .Clock (clk),
    .Reset (rst),
    .Flush (flush),
    .bus   (bus0)
  );

  pipe_skid_reg #(
    .WID_DATA          (8),
    .RST_VALUE         (8'hA5),
    .FLUSH_CLEARS_DATA (1'b1)
  ) dut_clear (
    .Clock (clk),
    .Reset (rst),
    .Flush (flush),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic ov, input logic ir,
                            input logic [1:0] cnt, input logic [7:0] dout);
    check({tag, " keep.OutValid"},  32'(bus0.OutValid), 32'(ov));
    check({tag, " keep.InReady"},   32'(bus0.InReady),  32'(ir));
    check({tag, " keep.Count"},     32'(bus0.Count),    32'(cnt));
    check({tag, " keep.DataOut"},   32'(bus0.DataOut),  32'(dout));
    check({tag, " clear.OutValid"}, 32'(bus1.OutValid), 32'(ov));
    check({tag, " clear.Count"},    32'(bus1.Count),    32'(cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sb[$];
    logic       exp_ov, exp_ir, in_fire, out_fire;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check_both("reset", 1'b0, 1'b1, 2'd0, 8'hA5);
    check("reset clear.DataOut", 32'(bus1.DataOut), 32'h0000_00A5);

    // Full-rate stream
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = 8'(i);
      tick();
      check_both($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'(i));
    end
    in_valid = 1'b0;
    tick();
    check_both("stream drain", 1'b0, 1'b1, 2'd0, 8'h10);

    // Stall into skid, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h11;
    tick();
    check_both("skid push1", 1'b1, 1'b1, 2'd1, 8'h11);
    data_in = 8'h22;
    tick();
    check_both("skid push2", 1'b1, 1'b0, 2'd2, 8'h11);
    data_in = 8'h99;
    tick();
    check_both("skid hold", 1'b1, 1'b0, 2'd2, 8'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_both("skid pop1", 1'b1, 1'b1, 2'd1, 8'h22);
    tick();
    check_both("skid pop2", 1'b0, 1'b1, 2'd0, 8'h22);

    // Flush from SKID with an input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h33;
    tick();
    data_in = 8'h44;
    tick();
    check_both("flush pre", 1'b1, 1'b0, 2'd2, 8'h33);
    flush   = 1'b1;
    data_in = 8'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_both("flush skid", 1'b0, 1'b1, 2'd0, 8'h33);
    check("flush skid clear.DataOut", 32'(bus1.DataOut), 32'h0000_00A5);
    out_ready = 1'b1;
    tick();
    check_both("flush after1", 1'b0, 1'b1, 2'd0, 8'h33);
    tick();
    check_both("flush after2", 1'b0, 1'b1, 2'd0, 8'h33);

    // Flush in FULL while the output handshake completes
    in_valid = 1'b1;
    data_in  = 8'h77;
    tick();
    check_both("flushfull pre", 1'b1, 1'b1, 2'd1, 8'h77);
    flush   = 1'b1;
    data_in = 8'h88;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_both("flushfull", 1'b0, 1'b1, 2'd0, 8'h77);
    check("flushfull clear.DataOut", 32'(bus1.DataOut), 32'h0000_00A5);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h66;
    tick();
    check_both("rstfull pre", 1'b1, 1'b1, 2'd1, 8'h66);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_both("rstfull", 1'b0, 1'b1, 2'd0, 8'hA5);
    out_ready = 1'b1;
    tick();
    check_both("rstfull after1", 1'b0, 1'b1, 2'd0, 8'hA5);
    tick();
    check_both("rstfull after2", 1'b0, 1'b1, 2'd0, 8'hA5);

    // Random handshakes against a scoreboard FIFO
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      data_in   = 8'($urandom_range(0, 255));
      exp_ov = (sb.size() != 0);
      exp_ir = (sb.size() < 2);
      check("rand OutValid", 32'(bus0.OutValid), 32'(exp_ov));
      check("rand InReady",  32'(bus0.InReady),  32'(exp_ir));
      check("rand Count",    32'(bus0.Count),    32'(sb.size()));
      check("rand clear.Count", 32'(bus1.Count), 32'(sb.size()));
      if (exp_ov) begin
        check("rand DataOut", 32'(bus0.DataOut), 32'(sb[0]));
        check("rand clear.DataOut", 32'(bus1.DataOut), 32'(sb[0]));
      end
      in_fire  = in_valid && exp_ir;
      out_fire = exp_ov && out_ready;
      tick();
      if (out_fire) void'(sb.pop_front());
      if (in_fire) sb.push_back(data_in);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pipe_skid_reg
